// File: rtl/atuador_dampers.sv
// ============================================================================
// Module   : atuador_dampers
// Purpose  : Per-damper open/close motor sequencer with limit-switch
//            confirmation, travel timeout and latched fault handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module atuador_dampers #(
  parameter int NUM_DAMPERS   = 6,
  parameter int TRAVEL_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DAMPERS-1:0] cmdDamper,
  input  logic [NUM_DAMPERS-1:0] fimCursoAberto,
  input  logic [NUM_DAMPERS-1:0] fimCursoFechado,
  input  logic                   ackFalha,
  output logic [NUM_DAMPERS-1:0] motorAbrir,
  output logic [NUM_DAMPERS-1:0] motorFechar,
  output logic [NUM_DAMPERS-1:0] estadoAberto,
  output logic [NUM_DAMPERS-1:0] falhaDamper,
  output logic                   alarmeAtuador
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TRAVEL_CYCLES);

  localparam logic [2:0] S_FECHADO  = 3'd0;
  localparam logic [2:0] S_ABRINDO  = 3'd1;
  localparam logic [2:0] S_ABERTO   = 3'd2;
  localparam logic [2:0] S_FECHANDO = 3'd3;
  localparam logic [2:0] S_FALHA    = 3'd4;

  for (genvar i = 0; i < NUM_DAMPERS; i++) begin : g_ch
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          cmd, lim_ab, lim_fe;
    logic          out_abrir, out_fechar, out_aberto, out_falha;

    assign cmd    = cmdDamper[i];
    assign lim_ab = fimCursoAberto[i];
    assign lim_fe = fimCursoFechado[i];

    // Saturating increment; the FALHA transition normally fires first.
    assign timer_inc = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_FECHADO;
        timer_q <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (lim_ab && lim_fe) begin
        // Contradictory limit switches override every other transition.
        state_d = S_FALHA;
      end else begin
        case (state_q)
          S_FECHADO: begin
            if (cmd) begin
              state_d = S_ABRINDO;
              timer_d = '0;
            end
          end
          S_ABRINDO: begin
            if (lim_ab) begin
              state_d = S_ABERTO;
            end else if (!cmd) begin
              state_d = S_FECHANDO;
              timer_d = '0;
            end else if (timer_q == T_LAST) begin
              state_d = S_FALHA;
            end else begin
              timer_d = timer_inc;
            end
          end
          S_ABERTO: begin
            if (!cmd) begin
              state_d = S_FECHANDO;
              timer_d = '0;
            end
          end
          S_FECHANDO: begin
            if (lim_fe) begin
              state_d = S_FECHADO;
            end else if (cmd) begin
              state_d = S_ABRINDO;
              timer_d = '0;
            end else if (timer_q == T_LAST) begin
              state_d = S_FALHA;
            end else begin
              timer_d = timer_inc;
            end
          end
          S_FALHA: begin
            // On release, anything short of a confirmed closed position is driven shut.
            if (ackFalha) begin
              if (lim_fe && !lim_ab) begin
                state_d = S_FECHADO;
              end else begin
                state_d = S_FECHANDO;
                timer_d = '0;
              end
            end
          end
          default: begin
            state_d = S_FECHADO;
            timer_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      out_abrir  = 1'b0;
      out_fechar = 1'b0;
      out_aberto = 1'b0;
      out_falha  = 1'b0;
      case (state_q)
        S_ABRINDO:  out_abrir  = 1'b1;
        S_ABERTO:   out_aberto = 1'b1;
        S_FECHANDO: out_fechar = 1'b1;
        S_FALHA:    out_falha  = 1'b1;
        default:    out_abrir  = 1'b0;
      endcase
    end

    assign motorAbrir[i]   = out_abrir;
    assign motorFechar[i]  = out_fechar;
    assign estadoAberto[i] = out_aberto;
    assign falhaDamper[i]  = out_falha;
  end

  assign alarmeAtuador = |falhaDamper;

endmodule

`default_nettype wire

// File: tb/tb_atuador_dampers.sv
// ============================================================================
// Module   : tb_atuador_dampers
// Purpose  : Directed and randomized checks of atuador_dampers against a
//            travel-counting damper model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_atuador_dampers;

  localparam int N = 6;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cmd = '0;
  logic [N-1:0] ab  = '0;
  logic [N-1:0] fe  = '0;
  logic         ack = 1'b0;
  logic [N-1:0] mot_ab, mot_fe, est_ab, falha;
  logic         alarme;

  int errors = 0;
  int checks = 0;

  atuador_dampers #(.NUM_DAMPERS(N), .TRAVEL_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .cmdDamper(cmd), .fimCursoAberto(ab),
    .fimCursoFechado(fe), .ackFalha(ack), .motorAbrir(mot_ab),
    .motorFechar(mot_fe), .estadoAberto(est_ab), .falhaDamper(falha),
    .alarmeAtuador(alarme)
  );

  always #5 clk = ~clk;

  // Model: what each damper is doing, and how long its motor has been running.
  typedef enum int {CLOSED, OPENING, OPEN, CLOSING, FAULT} mode_t;
  mode_t mode [N];
  int    run  [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = CLOSED;
      run[i]  = 0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (ab[i] && fe[i]) begin
        mode[i] = FAULT;
      end else if (mode[i] == CLOSED && cmd[i]) begin
        mode[i] = OPENING; run[i] = 0;
      end else if (mode[i] == OPEN && !cmd[i]) begin
        mode[i] = CLOSING; run[i] = 0;
      end else if (mode[i] == OPENING || mode[i] == CLOSING) begin
        bit going_open = (mode[i] == OPENING);
        if (going_open ? ab[i] : fe[i]) begin
          mode[i] = going_open ? OPEN : CLOSED;
        end else if (going_open != cmd[i]) begin
          mode[i] = going_open ? CLOSING : OPENING; run[i] = 0;
        end else begin
          run[i] = run[i] + 1;
          if (run[i] >= T) mode[i] = FAULT;
        end
      end else if (mode[i] == FAULT && ack) begin
        if (fe[i] && !ab[i]) mode[i] = CLOSED;
        else begin mode[i] = CLOSING; run[i] = 0; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_ab, e_fe, e_op, e_fa;
    for (int i = 0; i < N; i++) begin
      e_ab[i] = (mode[i] == OPENING);
      e_fe[i] = (mode[i] == CLOSING);
      e_op[i] = (mode[i] == OPEN);
      e_fa[i] = (mode[i] == FAULT);
    end
    chk("motorAbrir",   32'(mot_ab), 32'(e_ab));
    chk("motorFechar",  32'(mot_fe), 32'(e_fe));
    chk("estadoAberto", 32'(est_ab), 32'(e_op));
    chk("falhaDamper",  32'(falha),  32'(e_fa));
    chk("alarmeAtuador", 32'(alarme), 32'(|e_fa));
    chk("motor_overlap", 32'(mot_ab & mot_fe), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cnt;
    model_reset();

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("reset_alarme", 32'(alarme), 32'd0);

    // 1. Normal open on channel 0
    cmd = 6'b000001;
    cnt = 0;
    repeat (4) begin tick(); cnt += int'(mot_ab[0]); end
    ab[0] = 1'b1;
    tick();
    chk("t1_motor_cycles", 32'(cnt), 32'd4);
    chk("t1_aberto", 32'(est_ab), 32'b000001);
    chk("t1_idle_others", 32'(mot_ab | mot_fe), 32'd0);

    // 2. Open timeout on channel 2, then ack drives it closed
    cmd[2] = 1'b1;
    cnt = 0;
    repeat (12) begin tick(); cnt += int'(mot_ab[2]); end
    chk("t2_motor_cycles", 32'(cnt), 32'd8);
    chk("t2_falha", 32'(falha[2]), 32'd1);
    chk("t2_alarme", 32'(alarme), 32'd1);
    cmd[2] = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t2_fechar_after_ack", 32'(mot_fe[2]), 32'd1);
    chk("t2_falha_cleared", 32'(falha[2]), 32'd0);
    tick();
    fe[2] = 1'b1;
    tick();

    // 3. Reversal on channel 1
    cmd[1] = 1'b1;
    repeat (3) tick();
    cmd[1] = 1'b0;
    tick();
    chk("t3_abrir_drop", 32'(mot_ab[1]), 32'd0);
    chk("t3_fechar_on", 32'(mot_fe[1]), 32'd1);
    fe[1] = 1'b1;
    tick();
    chk("t3_closed", 32'({mot_ab[1], mot_fe[1], est_ab[1]}), 32'd0);

    // 4. Sensor fault on channel 4 while open; ack cannot release it
    cmd[4] = 1'b1;
    tick();
    ab[4] = 1'b1;
    tick();
    chk("t4_aberto", 32'(est_ab[4]), 32'd1);
    fe[4] = 1'b1;
    tick();
    chk("t4_sensor_fault", 32'(falha[4]), 32'd1);
    ack = 1'b1;
    repeat (2) tick();
    chk("t4_hold_fault", 32'(falha[4]), 32'd1);
    ab[4] = 1'b0;
    cmd[4] = 1'b0;
    tick();
    ack = 1'b0;
    chk("t4_released_closed", 32'({falha[4], mot_fe[4]}), 32'd0);

    // 5. Channels 0 and 5 both time out; a single ack clears both
    cmd[0] = 1'b0;
    ab[0] = 1'b0;
    cmd[5] = 1'b1;
    repeat (10) tick();
    chk("t5_both_fault", 32'(falha & 6'b100001), 32'b100001);
    cmd[5] = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t5_falha_cleared", 32'(falha), 32'd0);
    chk("t5_alarme_cleared", 32'(alarme), 32'd0);
    fe[0] = 1'b1;
    fe[5] = 1'b1;
    tick();

    // 6. Asynchronous reset during channel 3 travel
    fe[3] = 1'b0;
    cmd[3] = 1'b1;
    repeat (6) tick();
    chk("t6_traveling", 32'(mot_ab[3]), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_drop", 32'(mot_ab[3]), 32'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(mot_ab[3]); end
    chk("t6_full_timeout_after_reset", 32'(cnt), 32'd8);
    cmd[3] = 1'b0;
    fe[3] = 1'b1;
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) cmd[i] = ~cmd[i];
        ab[i] = ($urandom_range(5) == 0);
        fe[i] = ($urandom_range(5) == 0);
      end
      ack = ($urandom_range(11) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/atuador_dampers.md
# atuador_dampers

Damper actuator sequencer for the ventilation subsystem. It sits downstream of the ventilation controller and takes the six per-damper open/close commands. It drives each damper's open and close motor lines, confirms travel against the damper's limit switches, and enforces a per-damper travel timeout. Travel and sensor faults latch until the operator acknowledges them, and they raise a sonorous actuator alarm.

## Interface
- NUM_DAMPERS, 6: number of damper channels. Bit order is RSR, S3SR, S23, S12, S3SS, SSSC (bit 0 to bit 5).
- TRAVEL_CYCLES, 1000: maximum clock cycles a motor may run before the channel faults. Must be ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmdDamper  in  NUM_DAMPERS  1 = damper commanded open, 0 = commanded closed.
- fimCursoAberto  in  NUM_DAMPERS  fully-open limit switch, 1 = reached.
- fimCursoFechado  in  NUM_DAMPERS  fully-closed limit switch, 1 = reached.
- ackFalha  in  1  operator fault acknowledge; level sampled each cycle.
- motorAbrir  out  NUM_DAMPERS  drive the open motor.
- motorFechar  out  NUM_DAMPERS  drive the close motor.
- estadoAberto  out  NUM_DAMPERS  1 while the channel is in ABERTO.
- falhaDamper  out  NUM_DAMPERS  1 while the channel is in FALHA.
- alarmeAtuador  out  1  OR of all falhaDamper bits.

## Operation
- Each channel has an independent state machine with five states: FECHADO, ABRINDO, ABERTO, FECHANDO, FALHA. Each channel also has a travel timer of width clog2(TRAVEL_CYCLES+1).
- Reset values: all channels in FECHADO, all timers 0, all outputs 0.
- Per-state behaviour, in priority order within each state:
  - FECHADO: cmd=1 → ABRINDO, timer cleared.
  - ABRINDO (motorAbrir=1):
    - fimCursoAberto=1 → ABERTO.
    - else cmd=0 → FECHANDO, timer cleared (reversal).
    - else timer==TRAVEL_CYCLES-1 → FALHA.
    - else timer+1.
  - ABERTO: cmd=0 → FECHANDO, timer cleared.
  - FECHANDO (motorFechar=1): mirror of ABRINDO, using fimCursoFechado for completion and cmd=1 for reversal to ABRINDO.
  - FALHA (both motors 0):
    - Stays in FALHA until ackFalha=1.
    - On ack, exits to FECHADO if fimCursoFechado=1 and fimCursoAberto=0.
    - Otherwise exits to FECHANDO with the timer cleared, i.e. the damper is driven to its safe closed position.
    - The current command is then re-evaluated from that state on the following cycles.
- Sensor fault: fimCursoAberto=1 and fimCursoFechado=1 together on one channel. From any state, that channel goes to FALHA on the next edge. This has priority over every other transition, including ack.
- A single ackFalha cycle releases every channel in FALHA at once. Channels not in FALHA ignore ack.
- Invariant: motorAbrir[i] and motorFechar[i] are never both 1.
- The timer saturates and never wraps. It is meaningful only in ABRINDO and FECHANDO.

## Timing
- All outputs are Moore-decoded from registered state; there is no combinational path from inputs to outputs.
- Command latency: a cmd edge sampled at edge n takes effect on the motor output after edge n.
- Timeout: the motor is asserted for exactly TRAVEL_CYCLES cycles. falhaDamper rises on the following edge, and the motor drops the same cycle.
- Limit reached: the motor drops one edge after the limit switch is sampled high.
- alarmeAtuador asserts in the same cycle as falhaDamper.
- Fault release: ack sampled at edge n, falhaDamper=0 after edge n.
- Reset mid-travel: motors drop immediately on rst assertion, asynchronously. After rst is released, the first active edge evaluates from FECHADO.

## Test plan
Run with TRAVEL_CYCLES=8.
1. Normal open: cmdDamper=6'b000001; fimCursoAberto[0] rises 3 cycles later → motorAbrir[0]=1 for exactly 4 cycles, then estadoAberto[0]=1. All other channels stay idle.
2. Open timeout: cmdDamper[2]=1, no limit switch → motorAbrir[2]=1 for exactly 8 cycles, then falhaDamper[2]=1 and alarmeAtuador=1. Pulsing ackFalha with fimCursoFechado[2]=0 → FECHANDO, motorFechar[2]=1 on the next cycle.
3. Reversal: cmdDamper[1]=1 for 3 cycles, then 0 → motorAbrir[1] drops and motorFechar[1]=1 on the next cycle, with no overlap. Raising fimCursoFechado[1] returns the channel to FECHADO.
4. Sensor fault: channel 4 in ABERTO, then both limit switches high → falhaDamper[4]=1 next cycle. Holding ackFalha=1 with both limits still high keeps FALHA.
5. Multi-channel ack: channels 0 and 5 timed out → a single ackFalha cycle clears both; alarmeAtuador=0 on the next cycle.
6. Reset mid-travel: channel 3 in ABRINDO at timer=5, rst=1 → motorAbrir[3]=0 asynchronously. After release, the channel restarts from FECHADO with timer 0.
